// File: rtl/vec_mem_arbiter_if.sv
// Bus bundle between the load/store pipeline, the vector memory arbiter and
// the single-port data memory.
//   scalar : s_req/s_we/s_addr/s_wdata in, s_ack/s_rdata out
//   vector : v_req/v_we/v_addr/v_wdata/v_rd in, v_done/v_rdata/v_rd_out out
//   memory : mem_addr/mem_we/mem_wdata out, mem_rdata in (one cycle latency)
//   stall  : pipeline freeze
// slave  = arbiter side, master = requester + memory side.
interface vec_mem_arbiter_if #(
   parameter int DATA_W = 16,
   parameter int LANES  = 16,
   parameter int ADDR_W = 16
);
   logic                         s_req;
   logic                         s_we;
   logic [ADDR_W-1:0]            s_addr;
   logic [DATA_W-1:0]            s_wdata;
   logic                         s_ack;
   logic [DATA_W-1:0]            s_rdata;

   logic                         v_req;
   logic                         v_we;
   logic [ADDR_W-1:0]            v_addr;
   logic [LANES-1:0][DATA_W-1:0] v_wdata;
   logic [4:0]                   v_rd;
   logic                         v_done;
   logic [LANES-1:0][DATA_W-1:0] v_rdata;
   logic [4:0]                   v_rd_out;

   logic                         stall;

   logic [ADDR_W-1:0]            mem_addr;
   logic                         mem_we;
   logic [DATA_W-1:0]            mem_wdata;
   logic [DATA_W-1:0]            mem_rdata;

   modport slave (
      input  s_req, s_we, s_addr, s_wdata,
      output s_ack, s_rdata,
      input  v_req, v_we, v_addr, v_wdata, v_rd,
      output v_done, v_rdata, v_rd_out,
      output stall,
      output mem_addr, mem_we, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output s_req, s_we, s_addr, s_wdata,
      input  s_ack, s_rdata,
      output v_req, v_we, v_addr, v_wdata, v_rd,
      input  v_done, v_rdata, v_rd_out,
      input  stall,
      input  mem_addr, mem_we, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/vec_mem_arbiter.sv
// Shares the single-port synchronous data memory between the scalar and the
// vector load/store paths. Vector accesses stream LANES words, one per cycle,
// from/to consecutive (wrapping) addresses; loads are gathered into a full
// register image tagged with its destination register.
// Ports: clk, rst (async, active low), bus (vec_mem_arbiter_if.slave).
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | arbitrate between pending scalar and vector requests
//   S_ACC  | scalar address/command on the memory bus
//   S_RESP | scalar read data returns; ack issued on exit
//   V_RD   | vector load, idx 0..LANES (last step captures final word)
//   V_WR   | vector store, idx 0..LANES-1
module vec_mem_arbiter #(
   parameter int DATA_W = 16,
   parameter int LANES  = 16,
   parameter int ADDR_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   vec_mem_arbiter_if.slave bus
);

   localparam int IDX_W  = $clog2(LANES + 1);
   localparam int LANE_W = $clog2(LANES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LANES - 1);
   localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(LANES);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      S_ACC  = 3'd1,
      S_RESP = 3'd2,
      V_RD   = 3'd3,
      V_WR   = 3'd4
   } state_t;

   state_t                       state_q,    state_d;
   logic [IDX_W-1:0]             idx_q,      idx_d;
   logic                         last_vec_q, last_vec_d;
   logic [ADDR_W-1:0]            addr_q,     addr_d;
   logic                         s_we_q,     s_we_d;
   logic [DATA_W-1:0]            s_wdata_q,  s_wdata_d;
   logic [LANES-1:0][DATA_W-1:0] v_wdata_q,  v_wdata_d;
   logic                         s_ack_q,    s_ack_d;
   logic [DATA_W-1:0]            s_rdata_q,  s_rdata_d;
   logic                         v_done_q,   v_done_d;
   logic [LANES-1:0][DATA_W-1:0] v_rdata_q,  v_rdata_d;
   logic [4:0]                   v_rd_out_q, v_rd_out_d;

   logic              s_pend, v_pend, grant_s, grant_v;
   logic [LANE_W-1:0] lane_rd, lane_wr;
   logic [ADDR_W-1:0] mem_addr_c;
   logic              mem_we_c;
   logic [DATA_W-1:0] mem_wdata_c;

   // A request still high in its own ack/done cycle is the old one.
   assign s_pend  = bus.s_req & ~s_ack_q;
   assign v_pend  = bus.v_req & ~v_done_q;
   // On contention the side that did not win last time goes first.
   assign grant_s = s_pend & (~v_pend | last_vec_q);
   assign grant_v = v_pend & ~grant_s;

   // Load data returns one cycle behind its address, so step idx lands the
   // word for base+idx-1; lane order is reversed (base+k -> lane LANES-1-k).
   assign lane_rd = LANE_W'(LANES) - LANE_W'(idx_q);
   assign lane_wr = LANE_W'(LANES - 1) - LANE_W'(idx_q);

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      last_vec_d  = last_vec_q;
      addr_d      = addr_q;
      s_we_d      = s_we_q;
      s_wdata_d   = s_wdata_q;
      v_wdata_d   = v_wdata_q;
      s_ack_d     = 1'b0;
      s_rdata_d   = s_rdata_q;
      v_done_d    = 1'b0;
      v_rdata_d   = v_rdata_q;
      v_rd_out_d  = v_rd_out_q;
      mem_addr_c  = '0;
      mem_we_c    = 1'b0;
      mem_wdata_c = '0;

      case (state_q)
         IDLE: begin
            idx_d = '0;
            if (grant_s) begin
               state_d    = S_ACC;
               addr_d     = bus.s_addr;
               s_we_d     = bus.s_we;
               s_wdata_d  = bus.s_wdata;
               last_vec_d = 1'b0;
            end else if (grant_v) begin
               state_d    = bus.v_we ? V_WR : V_RD;
               addr_d     = bus.v_addr;
               v_wdata_d  = bus.v_wdata;
               last_vec_d = 1'b1;
               if (!bus.v_we) begin
                  v_rd_out_d = bus.v_rd;
               end
            end
         end
         S_ACC: begin
            mem_addr_c  = addr_q;
            mem_we_c    = s_we_q;
            mem_wdata_c = s_wdata_q;
            state_d     = S_RESP;
         end
         S_RESP: begin
            if (!s_we_q) begin
               s_rdata_d = bus.mem_rdata;
            end
            s_ack_d = 1'b1;
            state_d = IDLE;
         end
         V_RD: begin
            if (idx_q < IDX_END) begin
               mem_addr_c = addr_q + ADDR_W'(idx_q);
            end
            if (idx_q != '0) begin
               v_rdata_d[lane_rd] = bus.mem_rdata;
            end
            if (idx_q == IDX_END) begin
               v_done_d = 1'b1;
               idx_d    = '0;
               state_d  = IDLE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         V_WR: begin
            mem_addr_c  = addr_q + ADDR_W'(idx_q);
            mem_we_c    = 1'b1;
            mem_wdata_c = v_wdata_q[lane_wr];
            if (idx_q == IDX_LAST) begin
               v_done_d = 1'b1;
               idx_d    = '0;
               state_d  = IDLE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // Reset aborts any access in flight and clears partially gathered data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         last_vec_q <= 1'b1;
         addr_q     <= '0;
         s_we_q     <= 1'b0;
         s_wdata_q  <= '0;
         v_wdata_q  <= '0;
         s_ack_q    <= 1'b0;
         s_rdata_q  <= '0;
         v_done_q   <= 1'b0;
         v_rdata_q  <= '0;
         v_rd_out_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         last_vec_q <= last_vec_d;
         addr_q     <= addr_d;
         s_we_q     <= s_we_d;
         s_wdata_q  <= s_wdata_d;
         v_wdata_q  <= v_wdata_d;
         s_ack_q    <= s_ack_d;
         s_rdata_q  <= s_rdata_d;
         v_done_q   <= v_done_d;
         v_rdata_q  <= v_rdata_d;
         v_rd_out_q <= v_rd_out_d;
      end
   end

   assign bus.s_ack     = s_ack_q;
   assign bus.s_rdata   = s_rdata_q;
   assign bus.v_done    = v_done_q;
   assign bus.v_rdata   = v_rdata_q;
   assign bus.v_rd_out  = v_rd_out_q;
   assign bus.stall     = (state_q != IDLE) | s_pend | v_pend;
   assign bus.mem_addr  = mem_addr_c;
   assign bus.mem_we    = mem_we_c;
   assign bus.mem_wdata = mem_wdata_c;

endmodule

// File: tb/tb_vec_mem_arbiter.sv
module tb_vec_mem_arbiter;

   localparam int DATA_W = 16;
   localparam int LANES  = 16;
   localparam int ADDR_W = 16;

   typedef logic [LANES-1:0][DATA_W-1:0] vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   vec_mem_arbiter_if #(.DATA_W(DATA_W), .LANES(LANES), .ADDR_W(ADDR_W)) bus ();

   vec_mem_arbiter #(.DATA_W(DATA_W), .LANES(LANES), .ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Synchronous single-port memory plus a back door used for preloading.
   logic [15:0] mem [0:65535];
   logic        pl_en = 1'b0;
   logic [15:0] pl_addr = '0;
   logic [15:0] pl_data = '0;

   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
   end

   // Reference model: memory contents, last vector image/tag, last scalar read.
   logic [15:0] ref_mem [0:65535];
   vec_t        exp_vrdata = '0;
   logic [4:0]  exp_vrd = '0;
   logic [15:0] exp_srdata = '0;

   int errors = 0;
   int checks = 0;

   task automatic idle_inputs();
      bus.s_req = 0; bus.s_we = 0; bus.s_addr = '0; bus.s_wdata = '0;
      bus.v_req = 0; bus.v_we = 0; bus.v_addr = '0; bus.v_wdata = '0; bus.v_rd = '0;
   endtask

   task automatic preload(input logic [15:0] a, input logic [15:0] d);
      @(posedge clk); #1;
      pl_en = 1; pl_addr = a; pl_data = d; ref_mem[a] = d;
      @(posedge clk); #1;
      pl_en = 0;
   endtask

   task automatic scalar_op(input logic we, input logic [15:0] a, input logic [15:0] wd,
                            output int lat, output logic [15:0] rd);
      @(posedge clk); #1;
      bus.s_req = 1; bus.s_we = we; bus.s_addr = a; bus.s_wdata = wd;
      lat = -1; rd = '0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.s_ack) begin lat = c; rd = bus.s_rdata; break; end
      end
      bus.s_req = 0;
      if (we) ref_mem[a] = wd;
      else exp_srdata = ref_mem[a];
   endtask

   task automatic vec_op(input logic we, input logic [15:0] base, input vec_t wd, input logic [4:0] rd,
                         output int lat, output int we_cycles, output int stall_err);
      logic [15:0] a;
      @(posedge clk); #1;
      bus.v_req = 1; bus.v_we = we; bus.v_addr = base; bus.v_wdata = wd; bus.v_rd = rd;
      lat = -1; we_cycles = 0; stall_err = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (bus.mem_we) we_cycles++;
         if (bus.v_done) begin
            lat = c;
            if (bus.stall) stall_err++;
            break;
         end
         if (!bus.stall) stall_err++;
      end
      bus.v_req = 0;
      for (int k = 0; k < LANES; k++) begin
         a = base + 16'(k);
         if (we) ref_mem[a] = wd[LANES-1-k];
         else exp_vrdata[LANES-1-k] = ref_mem[a];
      end
      if (!we) exp_vrd = rd;
   endtask

   task automatic check_all_zero(input string tag);
      checks++;
      if (bus.s_ack !== 1'b0 || bus.s_rdata !== '0 || bus.v_done !== 1'b0 || bus.v_rdata !== '0 ||
          bus.v_rd_out !== '0 || bus.stall !== 1'b0 || bus.mem_addr !== '0 || bus.mem_we !== 1'b0 ||
          bus.mem_wdata !== '0) begin
         errors++;
         $display("FAIL %s: outputs not all zero (ack=%b srd=%h done=%b vrd_out=%0d stall=%b maddr=%h mwe=%b mwd=%h vrdata=%h)",
                  tag, bus.s_ack, bus.s_rdata, bus.v_done, bus.v_rd_out, bus.stall, bus.mem_addr,
                  bus.mem_we, bus.mem_wdata, bus.v_rdata);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 0;
      #3;
      check_all_zero("reset_during");
      repeat (3) @(negedge clk);
      rst = 1;
      repeat (2) @(negedge clk);
      check_all_zero("reset_after");
   endtask

   task automatic test_contention();
      int sa, vd, stall_low;
      logic [15:0] srd;
      for (int k = 0; k < LANES; k++) preload(16'h0100 + 16'(k), 16'hA000 + 16'(k));
      @(posedge clk); #1;
      bus.s_req = 1; bus.s_we = 0; bus.s_addr = 16'h0105;
      bus.v_req = 1; bus.v_we = 0; bus.v_addr = 16'h0100; bus.v_rd = 5'd3;
      sa = -1; vd = -1; stall_low = 0; srd = '0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (bus.s_ack && sa < 0) begin sa = c; srd = bus.s_rdata; bus.s_req = 0; end
         if (bus.v_done) begin vd = c; bus.v_req = 0; break; end
         if (!bus.stall) stall_low++;
      end
      exp_srdata = ref_mem[16'h0105];
      for (int k = 0; k < LANES; k++) exp_vrdata[LANES-1-k] = ref_mem[16'h0100 + 16'(k)];
      exp_vrd = 5'd3;
      checks++; if (sa !== 3) begin errors++; $display("FAIL cont_s_ack_cycle: got %0d expected 3", sa); end
      checks++; if (srd !== 16'hA005) begin errors++; $display("FAIL cont_s_rdata: got %h expected a005", srd); end
      checks++; if (vd !== 21) begin errors++; $display("FAIL cont_v_done_cycle: got %0d expected 21", vd); end
      checks++; if (stall_low !== 0) begin errors++; $display("FAIL cont_stall: low in %0d cycles expected 0", stall_low); end
      checks++; if (bus.v_rdata !== exp_vrdata) begin errors++; $display("FAIL cont_v_rdata: got %h expected %h", bus.v_rdata, exp_vrdata); end
      checks++; if (bus.v_rd_out !== 5'd3) begin errors++; $display("FAIL cont_v_rd_out: got %0d expected 3", bus.v_rd_out); end
   endtask

   task automatic test_vec_load();
      int lat, wec, se;
      vec_op(1'b0, 16'h0100, '0, 5'd7, lat, wec, se);
      checks++; if (lat !== 18) begin errors++; $display("FAIL vload_lat: got %0d expected 18", lat); end
      checks++; if (wec !== 0) begin errors++; $display("FAIL vload_mem_we: got %0d cycles expected 0", wec); end
      checks++; if (se !== 0) begin errors++; $display("FAIL vload_stall: %0d bad cycles expected 0", se); end
      checks++; if (bus.v_rdata !== exp_vrdata) begin errors++; $display("FAIL vload_data: got %h expected %h", bus.v_rdata, exp_vrdata); end
      checks++; if (bus.v_rdata[15] !== 16'hA000 || bus.v_rdata[0] !== 16'hA00F) begin
         errors++; $display("FAIL vload_lane_order: lane15=%h lane0=%h expected a000/a00f", bus.v_rdata[15], bus.v_rdata[0]);
      end
      checks++; if (bus.v_rd_out !== 5'd7) begin errors++; $display("FAIL vload_rd_out: got %0d expected 7", bus.v_rd_out); end
   endtask

   task automatic test_vec_store();
      int lat, wec, se, bad;
      vec_t wd;
      logic [15:0] a;
      for (int k = 0; k < LANES; k++) wd[LANES-1-k] = 16'h5500 + 16'(k);
      vec_op(1'b1, 16'h0200, wd, 5'd9, lat, wec, se);
      checks++; if (lat !== 17) begin errors++; $display("FAIL vstore_lat: got %0d expected 17", lat); end
      checks++; if (wec !== 16) begin errors++; $display("FAIL vstore_mem_we: got %0d cycles expected 16", wec); end
      checks++; if (se !== 0) begin errors++; $display("FAIL vstore_stall: %0d bad cycles expected 0", se); end
      bad = 0;
      for (int k = 0; k < LANES; k++) begin
         a = 16'h0200 + 16'(k);
         if (mem[a] !== 16'h5500 + 16'(k)) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL vstore_mem: %0d wrong words expected 0", bad); end
      checks++; if (bus.v_rdata !== exp_vrdata) begin errors++; $display("FAIL vstore_v_rdata_kept: got %h expected %h", bus.v_rdata, exp_vrdata); end
      checks++; if (bus.v_rd_out !== exp_vrd) begin errors++; $display("FAIL vstore_rd_out_kept: got %0d expected %0d", bus.v_rd_out, exp_vrd); end
   endtask

   task automatic test_scalar();
      int lat;
      logic [15:0] rd;
      scalar_op(1'b1, 16'h0040, 16'h1234, lat, rd);
      checks++; if (lat !== 3) begin errors++; $display("FAIL swrite_lat: got %0d expected 3", lat); end
      checks++; if (mem[16'h0040] !== 16'h1234) begin errors++; $display("FAIL swrite_mem: got %h expected 1234", mem[16'h0040]); end
      scalar_op(1'b0, 16'h0040, 16'h0000, lat, rd);
      checks++; if (lat !== 3) begin errors++; $display("FAIL sread_lat: got %0d expected 3", lat); end
      checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL sread_data: got %h expected 1234", rd); end
      scalar_op(1'b1, 16'h0041, 16'h7777, lat, rd);
      checks++; if (bus.s_rdata !== 16'h1234) begin errors++; $display("FAIL s_rdata_hold: got %h expected 1234", bus.s_rdata); end
   endtask

   task automatic test_back_to_back();
      int lat, a1, a2, acks;
      logic [15:0] rd, d1, d2;
      scalar_op(1'b1, 16'h0050, 16'hBEEF, lat, rd);
      scalar_op(1'b1, 16'h0051, 16'hCAFE, lat, rd);
      @(posedge clk); #1;
      bus.s_req = 1; bus.s_we = 0; bus.s_addr = 16'h0050;
      a1 = -1; a2 = -1; acks = 0; d1 = '0; d2 = '0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.s_ack) begin
            acks++;
            if (a1 < 0) begin a1 = c; d1 = bus.s_rdata; bus.s_addr = 16'h0051; end
            else begin a2 = c; d2 = bus.s_rdata; bus.s_req = 0; break; end
         end
      end
      bus.s_req = 0;
      exp_srdata = ref_mem[16'h0051];
      checks++; if (a1 !== 3 || d1 !== ref_mem[16'h0050]) begin errors++; $display("FAIL b2b_first: cycle %0d data %h expected 3/%h", a1, d1, ref_mem[16'h0050]); end
      checks++; if (a2 !== 7 || d2 !== ref_mem[16'h0051]) begin errors++; $display("FAIL b2b_second: cycle %0d data %h expected 7/%h", a2, d2, ref_mem[16'h0051]); end
      checks++; if (acks !== 2) begin errors++; $display("FAIL b2b_ack_count: got %0d expected 2", acks); end
   endtask

   task automatic test_wrap();
      int lat, wec, se;
      for (int k = 0; k < LANES; k++) preload(16'hFFF8 + 16'(k), 16'hC000 + 16'(k));
      vec_op(1'b0, 16'hFFF8, '0, 5'd11, lat, wec, se);
      checks++; if (lat !== 18) begin errors++; $display("FAIL wrap_lat: got %0d expected 18", lat); end
      checks++; if (bus.v_rdata !== exp_vrdata) begin errors++; $display("FAIL wrap_data: got %h expected %h", bus.v_rdata, exp_vrdata); end
      checks++; if (bus.v_rdata[7] !== 16'hC008 || bus.v_rdata[15] !== 16'hC000) begin
         errors++; $display("FAIL wrap_lanes: lane7=%h lane15=%h expected c008/c000", bus.v_rdata[7], bus.v_rdata[15]);
      end
   endtask

   task automatic test_reset_mid();
      int lat, wec, se, spurious;
      @(posedge clk); #1;
      bus.v_req = 1; bus.v_we = 0; bus.v_addr = 16'h0100; bus.v_rd = 5'd12;
      spurious = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.v_done) spurious++;
      end
      rst = 0;
      bus.v_req = 0;
      #1;
      check_all_zero("midreset_outputs");
      exp_vrdata = '0; exp_vrd = '0; exp_srdata = '0;
      repeat (3) @(negedge clk);
      rst = 1;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (bus.v_done || bus.stall) spurious++;
      end
      checks++; if (spurious !== 0) begin errors++; $display("FAIL midreset_no_done: %0d bad cycles expected 0", spurious); end
      vec_op(1'b0, 16'h0100, '0, 5'd12, lat, wec, se);
      checks++; if (lat !== 18) begin errors++; $display("FAIL midreset_reload_lat: got %0d expected 18", lat); end
      checks++; if (bus.v_rdata !== exp_vrdata || bus.v_rd_out !== 5'd12) begin
         errors++; $display("FAIL midreset_reload_data: got %h/%0d expected %h/12", bus.v_rdata, bus.v_rd_out, exp_vrdata);
      end
   endtask

   task automatic test_random();
      int lat, wec, se, kind;
      logic [15:0] a, wd, rd, exp;
      vec_t vwd;
      logic [4:0] rdreg;
      for (int j = 0; j < 4; j++) begin
         for (int k = 0; k < LANES; k++) vwd[k] = 16'($urandom);
         vec_op(1'b1, 16'h3000 + 16'(16 * j), vwd, 5'd0, lat, wec, se);
         checks++; if (lat !== 17 || wec !== 16) begin errors++; $display("FAIL rnd_init_store: lat %0d we %0d expected 17/16", lat, wec); end
      end
      for (int i = 0; i < 24; i++) begin
         kind = int'($urandom_range(0, 3));
         if (kind < 2) begin
            a = 16'h3000 + 16'($urandom_range(0, 63));
            wd = 16'($urandom);
            exp = (kind == 1) ? exp_srdata : ref_mem[a];
            scalar_op(kind == 1, a, wd, lat, rd);
            checks++; if (lat !== 3) begin errors++; $display("FAIL rnd_scalar_lat: op %0d got %0d expected 3", i, lat); end
            checks++; if (bus.s_rdata !== exp) begin errors++; $display("FAIL rnd_scalar_data: op %0d addr %h got %h expected %h", i, a, bus.s_rdata, exp); end
         end else begin
            a = 16'h3000 + 16'($urandom_range(0, 48));
            for (int k = 0; k < LANES; k++) vwd[k] = 16'($urandom);
            rdreg = 5'($urandom);
            vec_op(kind == 3, a, vwd, rdreg, lat, wec, se);
            checks++; if (lat !== ((kind == 3) ? 17 : 18) || se !== 0) begin errors++; $display("FAIL rnd_vec_timing: op %0d lat %0d stall_err %0d", i, lat, se); end
            checks++; if (bus.v_rdata !== exp_vrdata || bus.v_rd_out !== exp_vrd) begin
               errors++; $display("FAIL rnd_vec_data: op %0d got %h/%0d expected %h/%0d", i, bus.v_rdata, bus.v_rd_out, exp_vrdata, exp_vrd);
            end
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_contention();
      test_vec_load();
      test_vec_store();
      test_scalar();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
